// File: rtl/freq_meter.sv
// freq_meter: counts synchronized rising edges of sig_in over back-to-back windows of
// GATE_CYCLES clk_in cycles. Define FREQ_METER_BCD_EN to add the bcd_out/bcd_valid converter.
module freq_meter #(
    parameter int unsigned CLK_HZ      = 1_000_000,
    parameter int unsigned GATE_CYCLES = CLK_HZ,
    parameter int unsigned CNT_W       = 20,
    parameter int unsigned DIGITS      = 6
) (
    input  logic             clk_in,
    input  logic             rst_n,
    input  logic             en,
    input  logic             sig_in,
    output logic [CNT_W-1:0] freq_out,
    output logic             valid,
    output logic             overflow
`ifdef FREQ_METER_BCD_EN
    ,
    output logic [4*DIGITS-1:0] bcd_out,
    output logic                bcd_valid
`endif
);

    localparam int unsigned GW = (GATE_CYCLES > 1) ? $clog2(GATE_CYCLES) : 1;
    localparam logic [GW-1:0] GATE_LAST = GW'(GATE_CYCLES - 1);

    if (GATE_CYCLES < 2 || CNT_W < 1 || DIGITS < 1) begin : g_param_check
        $error("freq_meter: GATE_CYCLES must be >= 2, CNT_W and DIGITS >= 1");
    end

    typedef enum logic {
        IDLE,
        GATE
    } state_t;

    state_t           state;
    state_t           state_nx;
    logic             s1;
    logic             s2;
    logic             s3;
    logic             rise;
    logic [GW-1:0]    gate_cnt;
    logic [CNT_W-1:0] edge_cnt;
    logic [CNT_W-1:0] edge_sum;
    logic             ovf;
    logic             sat_now;
    logic             terminal;
    logic             count_en;
    logic             clear_cnt;
    logic             publish;

    // Two-flop synchronizer plus history flop; runs independently of en.
    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            s1 <= 1'b0;
            s2 <= 1'b0;
            s3 <= 1'b0;
        end else begin
            s1 <= sig_in;
            s2 <= s1;
            s3 <= s2;
        end
    end

    assign rise = s2 & ~s3;

    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        sat_now   = rise && (edge_cnt == '1);
        edge_sum  = sat_now ? edge_cnt : edge_cnt + CNT_W'(rise);
        terminal  = (state == GATE) && (gate_cnt == GATE_LAST);
        state_nx  = state;
        count_en  = 1'b0;
        clear_cnt = 1'b0;
        publish   = 1'b0;
        case (state)
            IDLE: begin
                clear_cnt = 1'b1;
                if (en) begin
                    state_nx = GATE;
                end
            end
            GATE: begin
                // The terminal cycle publishes even if en falls on that same cycle.
                if (terminal) begin
                    publish   = 1'b1;
                    clear_cnt = 1'b1;
                    if (!en) begin
                        state_nx = IDLE;
                    end
                end else if (!en) begin
                    clear_cnt = 1'b1;
                    state_nx  = IDLE;
                end else begin
                    count_en = 1'b1;
                end
            end
            default: begin
                clear_cnt = 1'b1;
                state_nx  = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            gate_cnt <= '0;
            edge_cnt <= '0;
            ovf      <= 1'b0;
        end else if (clear_cnt) begin
            gate_cnt <= '0;
            edge_cnt <= '0;
            ovf      <= 1'b0;
        end else if (count_en) begin
            gate_cnt <= gate_cnt + GW'(1);
            edge_cnt <= edge_sum;
            ovf      <= ovf | sat_now;
        end
    end

    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            freq_out <= '0;
            valid    <= 1'b0;
            overflow <= 1'b0;
        end else begin
            valid <= publish;
            if (publish) begin
                freq_out <= edge_sum;
                overflow <= ovf | sat_now;
            end
        end
    end

`ifdef FREQ_METER_BCD_EN
    localparam int unsigned BW = 4 * DIGITS;
    localparam int unsigned SW = $clog2(CNT_W + 1);

    logic [CNT_W-1:0] bin_sr;
    logic [BW-1:0]    bcd_sr;
    logic [BW-1:0]    bcd_adj;
    logic [SW-1:0]    shift_cnt;
    logic             done;

    always_comb begin
        bcd_adj = bcd_sr;
        for (int unsigned d = 0; d < DIGITS; d++) begin
            if (bcd_sr[4*d +: 4] >= 4'd5) begin
                bcd_adj[4*d +: 4] = bcd_sr[4*d +: 4] + 4'd3;
            end
        end
    end

    // Loads on the publish edge (same edge that raises valid) so bcd_valid trails valid
    // by CNT_W+1 cycles; digits shifted out of the top are dropped (mod 10^DIGITS).
    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            bin_sr    <= '0;
            bcd_sr    <= '0;
            shift_cnt <= '0;
            done      <= 1'b0;
            bcd_out   <= '0;
            bcd_valid <= 1'b0;
        end else begin
            bcd_valid <= done;
            if (done) begin
                bcd_out <= bcd_sr;
            end
            done <= 1'b0;
            if (publish) begin
                bin_sr    <= edge_sum;
                bcd_sr    <= '0;
                shift_cnt <= SW'(CNT_W);
            end else if (shift_cnt != '0) begin
                {bcd_sr, bin_sr} <= {bcd_adj, bin_sr} << 1;
                shift_cnt        <= shift_cnt - SW'(1);
                done             <= (shift_cnt == SW'(1));
            end
        end
    end
`endif

endmodule

// File: tb/tb_freq_meter.sv
// Directed bench for freq_meter: GATE_CYCLES=100 with CNT_W=20 and CNT_W=5 instances,
// plus a GATE_CYCLES=5000 BCD instance when FREQ_METER_BCD_EN is defined.
module tb_freq_meter;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        en = 1'b0;
    logic        sig = 1'b0;
    logic [19:0] freq_a;
    logic        valid_a;
    logic        ovf_a;
    logic [4:0]  freq_b;
    logic        valid_b;
    logic        ovf_b;

    int checks = 0;
    int errors = 0;
    int sig_period = 0;
    logic sig_hold = 1'b0;
    int ph = 0;

`ifdef FREQ_METER_BCD_EN
    logic [23:0] bcd_a;
    logic        bcd_valid_a;
    logic [7:0]  bcd_b;
    logic        bcd_valid_b;
    logic        en_c = 1'b0;
    logic [19:0] freq_c;
    logic        valid_c;
    logic        ovf_c;
    logic [23:0] bcd_c;
    logic        bcd_valid_c;
`endif

    freq_meter #(.CLK_HZ(100), .GATE_CYCLES(100), .CNT_W(20), .DIGITS(6)) dut_a (
        .clk_in(clk), .rst_n(rst_n), .en(en), .sig_in(sig),
        .freq_out(freq_a), .valid(valid_a), .overflow(ovf_a)
`ifdef FREQ_METER_BCD_EN
        , .bcd_out(bcd_a), .bcd_valid(bcd_valid_a)
`endif
    );

    freq_meter #(.CLK_HZ(100), .GATE_CYCLES(100), .CNT_W(5), .DIGITS(2)) dut_b (
        .clk_in(clk), .rst_n(rst_n), .en(en), .sig_in(sig),
        .freq_out(freq_b), .valid(valid_b), .overflow(ovf_b)
`ifdef FREQ_METER_BCD_EN
        , .bcd_out(bcd_b), .bcd_valid(bcd_valid_b)
`endif
    );

`ifdef FREQ_METER_BCD_EN
    freq_meter #(.CLK_HZ(5000), .GATE_CYCLES(5000), .CNT_W(20), .DIGITS(6)) dut_c (
        .clk_in(clk), .rst_n(rst_n), .en(en_c), .sig_in(sig),
        .freq_out(freq_c), .valid(valid_c), .overflow(ovf_c),
        .bcd_out(bcd_c), .bcd_valid(bcd_valid_c)
    );
`endif

    initial forever #5 clk = ~clk;

    // Test signal: square wave of sig_period clocks (high first half), or held level.
    initial forever begin
        @(negedge clk);
        if (sig_period < 2) begin
            sig = sig_hold;
        end else begin
            sig = (ph < sig_period / 2);
            ph = (ph + 1 >= sig_period) ? 0 : ph + 1;
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic wait_valid(input int limit, output int cycles, output bit seen);
        seen = 1'b0;
        cycles = 0;
        while (!seen && cycles < limit) begin
            @(negedge clk);
            cycles++;
            if (valid_a) seen = 1'b1;
        end
    endtask

    task automatic test_reset();
        bit bad = 1'b0;
        sig_period = 2;
        rst_n = 1'b0;
        repeat (8) begin
            @(negedge clk);
            if (freq_a !== 20'd0 || valid_a !== 1'b0 || ovf_a !== 1'b0 ||
                freq_b !== 5'd0 || valid_b !== 1'b0 || ovf_b !== 1'b0) bad = 1'b1;
        end
        checks++;
        if (bad) begin
            errors++;
            $display("FAIL reset_outputs: freq_a=%0d valid_a=%0b ovf_a=%0b required 0/0/0", freq_a, valid_a, ovf_a);
        end
        rst_n = 1'b1;
        bad = 1'b0;
        repeat (20) begin
            @(negedge clk);
            if (valid_a !== 1'b0 || freq_a !== 20'd0) bad = 1'b1;
        end
        checks++;
        if (bad) begin
            errors++;
            $display("FAIL idle_after_reset: valid_a=%0b freq_a=%0d required 0/0", valid_a, freq_a);
        end
    endtask

    task automatic test_period10();
        int c;
        bit s;
        sig_period = 10;
        repeat (5) @(negedge clk);
        en = 1'b1;
        wait_valid(200, c, s);
        checks++;
        if (!s || c != 101) begin
            errors++;
            $display("FAIL first_valid_latency: got %0d cycles (seen=%0b) required 101", c, s);
        end
        checks++;
        if (freq_a !== 20'd10 || ovf_a !== 1'b0) begin
            errors++;
            $display("FAIL first_window: freq=%0d ovf=%0b required 10/0", freq_a, ovf_a);
        end
        repeat (2) begin
            wait_valid(150, c, s);
            checks++;
            if (!s || c != 100) begin
                errors++;
                $display("FAIL valid_period: got %0d cycles (seen=%0b) required 100", c, s);
            end
            checks++;
            if (freq_a !== 20'd10 || freq_b !== 5'd10 || ovf_b !== 1'b0) begin
                errors++;
                $display("FAIL period10_window: freq_a=%0d freq_b=%0d ovf_b=%0b required 10/10/0", freq_a, freq_b, ovf_b);
            end
        end
        @(negedge clk);
        checks++;
        if (valid_a !== 1'b0) begin
            errors++;
            $display("FAIL valid_width: valid=%0b one cycle after pulse, required 0", valid_a);
        end
    endtask

    task automatic test_static_level();
        int c;
        bit s;
        for (int lvl = 0; lvl < 2; lvl++) begin
            sig_period = 0;
            sig_hold = lvl[0];
            wait_valid(150, c, s);
            wait_valid(150, c, s);
            checks++;
            if (!s || freq_a !== 20'd0 || ovf_a !== 1'b0) begin
                errors++;
                $display("FAIL static_level_%0d: freq=%0d ovf=%0b seen=%0b required 0/0/1", lvl, freq_a, ovf_a, s);
            end
        end
    endtask

    task automatic test_saturation();
        int c;
        bit s;
        sig_period = 2;
        wait_valid(150, c, s);
        wait_valid(150, c, s);
        checks++;
        if (!s || freq_b !== 5'd31 || ovf_b !== 1'b1) begin
            errors++;
            $display("FAIL saturate_cntw5: freq=%0d ovf=%0b required 31/1", freq_b, ovf_b);
        end
        checks++;
        if (freq_a !== 20'd50 || ovf_a !== 1'b0) begin
            errors++;
            $display("FAIL max_rate_cntw20: freq=%0d ovf=%0b required 50/0", freq_a, ovf_a);
        end
        sig_period = 10;
        wait_valid(150, c, s);
        wait_valid(150, c, s);
        checks++;
        if (!s || freq_b !== 5'd10 || ovf_b !== 1'b0) begin
            errors++;
            $display("FAIL recover_cntw5: freq=%0d ovf=%0b required 10/0", freq_b, ovf_b);
        end
    endtask

    task automatic test_abort_and_reset();
        int c;
        bit s;
        bit bad = 1'b0;
        wait_valid(150, c, s);
        repeat (40) @(negedge clk);
        en = 1'b0;
        repeat (150) begin
            @(negedge clk);
            if (valid_a !== 1'b0) bad = 1'b1;
        end
        checks++;
        if (bad) begin
            errors++;
            $display("FAIL abort_no_valid: valid pulsed after abort, required none");
        end
        checks++;
        if (freq_a !== 20'd10 || ovf_a !== 1'b0) begin
            errors++;
            $display("FAIL abort_hold: freq=%0d ovf=%0b required 10/0", freq_a, ovf_a);
        end
        en = 1'b1;
        wait_valid(200, c, s);
        checks++;
        if (!s || c != 101 || freq_a !== 20'd10) begin
            errors++;
            $display("FAIL reenable_window: cycles=%0d freq=%0d seen=%0b required 101/10/1", c, freq_a, s);
        end
        sig_period = 2;
        wait_valid(150, c, s);
        wait_valid(150, c, s);
        checks++;
        if (!s || ovf_b !== 1'b1 || freq_a !== 20'd50) begin
            errors++;
            $display("FAIL pre_reset_state: ovf_b=%0b freq_a=%0d required 1/50", ovf_b, freq_a);
        end
        repeat (50) @(negedge clk);
        rst_n = 1'b0;
        #1;
        checks++;
        if (freq_a !== 20'd0 || valid_a !== 1'b0 || freq_b !== 5'd0 || ovf_b !== 1'b0) begin
            errors++;
            $display("FAIL async_reset: freq_a=%0d valid_a=%0b freq_b=%0d ovf_b=%0b required 0/0/0/0", freq_a, valid_a, freq_b, ovf_b);
        end
        en = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (5) @(negedge clk);
    endtask

`ifdef FREQ_METER_BCD_EN
    task automatic test_bcd();
        int c = 0;
        int n = 0;
        bit s = 1'b0;
        sig_period = 4;
        repeat (10) @(negedge clk);
        en_c = 1'b1;
        while (!s && c < 5200) begin
            @(negedge clk);
            c++;
            if (valid_c) s = 1'b1;
        end
        checks++;
        if (!s || freq_c !== 20'd1250 || ovf_c !== 1'b0) begin
            errors++;
            $display("FAIL bcd_freq: freq=%0d ovf=%0b seen=%0b required 1250/0/1", freq_c, ovf_c, s);
        end
        s = 1'b0;
        while (!s && n < 40) begin
            @(negedge clk);
            n++;
            if (bcd_valid_c) s = 1'b1;
        end
        checks++;
        if (!s || n != 21) begin
            errors++;
            $display("FAIL bcd_latency: got %0d cycles (seen=%0b) required 21", n, s);
        end
        checks++;
        if (bcd_c !== 24'h001250) begin
            errors++;
            $display("FAIL bcd_value: got %h required 001250", bcd_c);
        end
        en_c = 1'b0;
    endtask
`endif

    initial begin
        test_reset();
        test_period10();
        test_static_level();
        test_saturation();
        test_abort_and_reset();
`ifdef FREQ_METER_BCD_EN
        test_bcd();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
